am9513_host_if: RTL

AM9513_HOST_IF -- requirements
Module: am9513_host_if

---
 rtl/am9513_host_if_if.sv | 29 ++
 rtl/am9513_host_if.sv | 117 +++++++++++
 2 files changed

// File: rtl/am9513_host_if_if.sv
// Host-side request/response and Am9513 bus pins for am9513_host_if.
// Host handshake: an access is accepted on a rising edge where req=1 and ready=1;
// ready is low for the whole access, and ack pulses for one clock when it completes.
interface am9513_host_if_if;
    logic        req;
    logic        cd;
    logic        we;
    logic [15:0] wdata;
    logic        ready;
    logic        ack;
    logic [15:0] rdata;
    logic        CS_n;
    logic        CD_n;
    logic        RD_n;
    logic        WR_n;
    logic [15:0] d_out;
    logic        d_oe;
    logic [15:0] d_in;

    modport master (
        output req, cd, we, wdata, d_in,
        input  ready, ack, rdata, CS_n, CD_n, RD_n, WR_n, d_out, d_oe
    );

    modport slave (
        input  req, cd, we, wdata, d_in,
        output ready, ack, rdata, CS_n, CD_n, RD_n, WR_n, d_out, d_oe
    );
endinterface

// File: rtl/am9513_host_if.sv
// Am9513 bus sequencer: turns one host request into a timed setup/strobe/hold/recover
// cycle on CS_n/CD_n/RD_n/WR_n with registered pins and a one-clock completion ack.
module am9513_host_if #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned STROBE_CYC   = 4,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RECOVERY_CYC = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    am9513_host_if_if.slave   bus,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    // Counter holds clocks remaining minus one, so phase ends when it reads zero.
    localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYC - 1);
    localparam logic [7:0] RECOVER_LD = 8'(RECOVERY_CYC - 1);

    logic [2:0] state;
    logic [7:0] cnt;
    logic       lat_we;
    logic       last;

    assign last      = (cnt == 8'd0);
    assign dbg_state = state;
    assign bus.ready = (state == S_IDLE);
    assign bus.ack   = (state == S_HOLD) && last;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            lat_we    <= 1'b0;
            bus.CS_n  <= 1'b1;
            bus.CD_n  <= 1'b1;
            bus.RD_n  <= 1'b1;
            bus.WR_n  <= 1'b1;
            bus.d_oe  <= 1'b0;
            bus.d_out <= 16'h0000;
            bus.rdata <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        state    <= S_SETUP;
                        cnt      <= SETUP_LD;
                        lat_we   <= bus.we;
                        bus.CS_n <= 1'b0;
                        bus.CD_n <= bus.cd;
                        bus.d_oe <= bus.we;
                        if (bus.we) begin
                            bus.d_out <= bus.wdata;
                        end
                    end
                end
                S_SETUP: begin
                    if (last) begin
                        state <= S_STROBE;
                        cnt   <= STROBE_LD;
                        if (lat_we) begin
                            bus.WR_n <= 1'b0;
                        end else begin
                            bus.RD_n <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_STROBE: begin
                    // Read data is sampled on the final strobe clock, just before RD_n rises.
                    if (last) begin
                        state    <= S_HOLD;
                        cnt      <= HOLD_LD;
                        bus.RD_n <= 1'b1;
                        bus.WR_n <= 1'b1;
                        if (!lat_we) begin
                            bus.rdata <= bus.d_in;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (last) begin
                        state    <= S_RECOVER;
                        cnt      <= RECOVER_LD;
                        bus.CS_n <= 1'b1;
                        bus.d_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RECOVER: begin
                    if (last) begin
                        state <= S_IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule
